// File: rtl/hyper_ram_emu.sv
// HyperBus responder that emulates a HyperRAM device on top of block RAM.
// All HyperBus pins are oversampled in the wb_clk_i domain (wb_clk_i >= 4x hb_ck).
//
// Ports:
//   wb_clk_i, wb_rst_ni      system clock, asynchronous active-low reset
//   hb_ck_i, hb_cs_ni        HyperBus clock (sampled as data) and chip select
//   hb_rst_ni                device reset from the initiator (synchronous, RAM kept)
//   hb_dq_i/o, hb_dq_oe      DQ bus, split into input, output and output enable
//   hb_rwds_i/o, hb_rwds_oe  RWDS, split likewise (input = write byte mask)
//   cr0_o                    current configuration register 0
module hyper_ram_emu #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 6,
  parameter logic [15:0] ID0_VAL = 16'h0C81,
  parameter logic [15:0] CR0_RST = 16'h8F1F
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        hb_ck_i,
  input  logic        hb_cs_ni,
  input  logic        hb_rst_ni,
  input  logic [7:0]  hb_dq_i,
  output logic [7:0]  hb_dq_o,
  output logic        hb_dq_oe,
  input  logic        hb_rwds_i,
  output logic        hb_rwds_o,
  output logic        hb_rwds_oe,
  output logic [15:0] cr0_o
);

  typedef enum logic [2:0] {StIdle, StCa, StLat, StRd, StWr, StRegWr, StDone} state_e;

  localparam logic [7:0] Lat1x = 8'(LATENCY);
  localparam logic [7:0] Lat2x = 8'(2 * LATENCY);

  state_e              state_q;
  logic                ck_q, ck_qq, cs_q, cs_qq, rwds_q;
  logic [7:0]          dq_q;
  logic [39:0]         ca_q;       // first five CA bytes; the sixth is taken from dq_q
  logic [2:0]          ca_cnt_q;
  logic [7:0]          cnt_q;
  logic [2:0]          cmd_q;      // {read, register space, linear}
  logic [31:0]         raddr_q;    // untruncated word address for register decode
  logic [ADDR_W-1:0]   addr_q;
  logic                two_x_q;
  logic [7:0]          hi_q;
  logic                hi_en_q;
  logic                half_q;     // upper byte of the current word already handled
  logic [15:0]         cr0_q;
  logic [15:0]         ram_q;
  logic [15:0]         mem_q [2**ADDR_W];

  logic                rise, fall, ck_edge;
  logic [31:0]         ca_addr;
  logic [7:0]          lat_init;
  logic [15:0]         reg_rdata, rd_word;
  logic [ADDR_W-1:0]   addr_inc;
  logic                ram_we;

  assign rise     = ck_q & ~ck_qq;
  assign fall     = ~ck_q & ck_qq;
  assign ck_edge  = rise | fall;
  assign ca_addr  = {ca_q[36:8], dq_q[2:0]};
  assign lat_init = two_x_q ? Lat2x : Lat1x;
  assign cr0_o    = cr0_q;
  assign ram_we   = hb_rst_ni & ~cs_q & (state_q == StWr) & fall & half_q;

  always_comb begin
    reg_rdata = 16'h0000;
    if (raddr_q == 32'h0) begin
      reg_rdata = ID0_VAL;
    end else if (raddr_q[11]) begin
      reg_rdata = cr0_q;
    end
    rd_word = cmd_q[1] ? reg_rdata : ram_q;
    // Wrapped bursts stay inside the aligned 16-word group
    if (cmd_q[0]) begin
      addr_inc = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      addr_inc = {addr_q[ADDR_W-1:4], addr_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ck_q   <= 1'b0;
      ck_qq  <= 1'b0;
      cs_q   <= 1'b1;
      cs_qq  <= 1'b1;
      dq_q   <= 8'h00;
      rwds_q <= 1'b0;
    end else begin
      ck_q   <= hb_ck_i;
      ck_qq  <= ck_q;
      cs_q   <= hb_cs_ni;
      cs_qq  <= cs_q;
      dq_q   <= hb_dq_i;
      rwds_q <= hb_rwds_i;
    end
  end

  // Backing RAM: synchronous read of the current word, byte-enabled write
  always_ff @(posedge wb_clk_i) begin
    if (ram_we) begin
      if (hi_en_q) mem_q[addr_q][15:8] <= hi_q;
      if (!rwds_q) mem_q[addr_q][7:0]  <= dq_q;
    end
    ram_q <= mem_q[addr_q];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= StIdle;
      hb_dq_o    <= 8'h00;
      hb_dq_oe   <= 1'b0;
      hb_rwds_o  <= 1'b0;
      hb_rwds_oe <= 1'b0;
      cr0_q      <= CR0_RST;
      ca_q       <= '0;
      ca_cnt_q   <= '0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      raddr_q    <= '0;
      addr_q     <= '0;
      two_x_q    <= 1'b0;
      hi_q       <= '0;
      hi_en_q    <= 1'b0;
      half_q     <= 1'b0;
    end else if (!hb_rst_ni) begin
      state_q    <= StIdle;
      hb_dq_o    <= 8'h00;
      hb_dq_oe   <= 1'b0;
      hb_rwds_o  <= 1'b0;
      hb_rwds_oe <= 1'b0;
      cr0_q      <= CR0_RST;
      half_q     <= 1'b0;
    end else begin
      hb_dq_oe   <= 1'b0;
      hb_rwds_oe <= 1'b0;
      if (cs_q) begin
        state_q   <= StIdle;
        hb_dq_o   <= 8'h00;
        hb_rwds_o <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (cs_qq) begin
              state_q  <= StCa;
              ca_cnt_q <= '0;
              two_x_q  <= cr0_q[3];
            end
          end
          StCa: begin
            hb_rwds_oe <= 1'b1;
            hb_rwds_o  <= two_x_q;
            if (ck_edge) begin
              ca_q     <= {ca_q[31:0], dq_q};
              ca_cnt_q <= ca_cnt_q + 3'd1;
              if (ca_cnt_q == 3'd5) begin
                cmd_q   <= ca_q[39:37];
                raddr_q <= ca_addr;
                addr_q  <= ca_addr[ADDR_W-1:0];
                half_q  <= 1'b0;
                if (ca_q[38] && !ca_q[39]) begin
                  state_q <= StRegWr;
                end else if (lat_init == 8'd0) begin
                  state_q <= ca_q[39] ? StRd : StWr;
                end else begin
                  cnt_q   <= lat_init;
                  state_q <= StLat;
                end
              end
            end
          end
          StLat: begin
            hb_dq_o   <= 8'h00;
            hb_rwds_o <= 1'b0;
            if (rise) begin
              cnt_q <= cnt_q - 8'd1;
              if (cnt_q == 8'd1) state_q <= cmd_q[2] ? StRd : StWr;
            end
          end
          StRd: begin
            hb_dq_oe   <= 1'b1;
            hb_rwds_oe <= 1'b1;
            if (rise) begin
              hb_dq_o   <= rd_word[15:8];
              hb_rwds_o <= 1'b1;
              half_q    <= 1'b1;
            end else if (fall && half_q) begin
              // Advancing here leaves the RAM a full edge to fetch the next word
              hb_dq_o   <= rd_word[7:0];
              hb_rwds_o <= 1'b0;
              half_q    <= 1'b0;
              addr_q    <= addr_inc;
            end
          end
          StWr: begin
            if (rise) begin
              hi_q    <= dq_q;
              hi_en_q <= ~rwds_q;
              half_q  <= 1'b1;
            end else if (fall && half_q) begin
              half_q <= 1'b0;
              addr_q <= addr_inc;
            end
          end
          StRegWr: begin
            if (rise) begin
              hi_q   <= dq_q;
              half_q <= 1'b1;
            end else if (fall && half_q) begin
              if (raddr_q == 32'h800) cr0_q <= {hi_q, dq_q};
              state_q <= StDone;
            end
          end
          StDone: begin
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hyper_ram_emu.sv
module tb_hyper_ram_emu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hb_ck = 1'b0;
  logic        cs_n = 1'b1;
  logic        hb_rst_n = 1'b1;
  logic [7:0]  dq_i = 8'h00;
  logic        rwds_i = 1'b0;
  logic [7:0]  dq_o;
  logic        dq_oe;
  logic        rwds_o;
  logic        rwds_oe;
  logic [15:0] cr0;

  int n_tests = 0;
  int n_fail = 0;

  logic [15:0] wbuf [4];
  logic [1:0]  mbuf [4];
  logic [15:0] rbuf [4];
  logic [1:0]  rwbuf [4];
  logic        ca_oe, ca_rw;
  int          lat_meas, got;

  hyper_ram_emu #(
    .ADDR_W (10),
    .LATENCY(6),
    .ID0_VAL(16'h0C81),
    .CR0_RST(16'h8F1F)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .hb_ck_i   (hb_ck),
    .hb_cs_ni  (cs_n),
    .hb_rst_ni (hb_rst_n),
    .hb_dq_i   (dq_i),
    .hb_dq_o   (dq_o),
    .hb_dq_oe  (dq_oe),
    .hb_rwds_i (rwds_i),
    .hb_rwds_o (rwds_o),
    .hb_rwds_oe(rwds_oe),
    .cr0_o     (cr0)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One HyperBus transaction; hb_ck half period is 4 system clocks.
  task automatic xfer(input logic rd, input logic rg, input logic lin, input logic [31:0] addr,
                      input int n, input int wlat, input bit keep);
    logic [47:0] ca;
    logic [7:0]  hi;
    logic        rhi;
    int          guard;
    ca = {rd, rg, lin, addr[31:3], 13'h0, addr[2:0]};
    hb_ck = 1'b0;
    rwds_i = 1'b0;
    wait_clk(4);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 6; i++) begin
      dq_i = ca[47-8*i -: 8];
      hb_ck = ~hb_ck;
      wait_clk(2);
      if (i == 2) begin
        ca_oe = rwds_oe;
        ca_rw = rwds_o;
      end
      wait_clk(2);
    end
    got = 0;
    lat_meas = 0;
    if (rd) begin
      guard = 0;
      while (got < n && guard < 40) begin
        guard++;
        hb_ck = 1'b1;
        wait_clk(3);
        if (dq_oe && rwds_oe && rwds_o) begin
          hi = dq_o;
          rhi = rwds_o;
          hb_ck = 1'b0;
          wait_clk(3);
          rbuf[got] = {hi, dq_o};
          rwbuf[got] = {rhi, rwds_o};
          got++;
          wait_clk(1);
        end else begin
          if (got == 0) lat_meas++;
          hb_ck = 1'b0;
          wait_clk(4);
        end
      end
    end else begin
      repeat (wlat) begin
        hb_ck = 1'b1;
        wait_clk(4);
        hb_ck = 1'b0;
        wait_clk(4);
      end
      for (int w = 0; w < n; w++) begin
        dq_i = wbuf[w][15:8];
        rwds_i = mbuf[w][1];
        hb_ck = 1'b1;
        wait_clk(4);
        dq_i = wbuf[w][7:0];
        rwds_i = mbuf[w][0];
        hb_ck = 1'b0;
        wait_clk(4);
      end
      got = n;
    end
    if (!keep) begin
      cs_n = 1'b1;
      rwds_i = 1'b0;
      wait_clk(4);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);
    n_tests++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_oe: dq_oe=%b rwds_oe=%b, expected 0 0", dq_oe, rwds_oe);
    end
    n_tests++;
    if (dq_o !== 8'h00 || rwds_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: dq_o=%h rwds_o=%b, expected 00 0", dq_o, rwds_o);
    end
    n_tests++;
    if (cr0 !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL reset_cr0: got %h, expected 8f1f", cr0);
    end
  endtask

  task automatic test_cr0();
    wbuf[0] = 16'h8F17;
    mbuf[0] = 2'b11;
    xfer(1'b0, 1'b1, 1'b1, 32'h800, 1, 0, 1'b0);
    n_tests++;
    if (ca_oe !== 1'b1 || ca_rw !== 1'b1) begin
      n_fail++;
      $display("FAIL cr0_ca_2x: rwds_oe=%b rwds=%b, expected 1 1", ca_oe, ca_rw);
    end
    n_tests++;
    if (cr0 !== 16'h8F17) begin
      n_fail++;
      $display("FAIL cr0_write: got %h, expected 8f17", cr0);
    end
    xfer(1'b1, 1'b1, 1'b1, 32'h800, 1, 0, 1'b0);
    n_tests++;
    if (got !== 1 || rbuf[0] !== 16'h8F17 || rwbuf[0] !== 2'b10) begin
      n_fail++;
      $display("FAIL cr0_read: words=%0d data=%h rwds=%b, expected 1 8f17 10",
               got, rbuf[0], rwbuf[0]);
    end
    n_tests++;
    if (ca_oe !== 1'b1 || ca_rw !== 1'b0 || lat_meas !== 6) begin
      n_fail++;
      $display("FAIL cr0_1x: rwds_oe=%b rwds=%b lat=%0d, expected 1 0 6", ca_oe, ca_rw, lat_meas);
    end
  endtask

  task automatic test_write_read();
    logic [15:0] exp [2];
    exp[0] = 16'hA1B2;
    exp[1] = 16'hC3D4;
    for (int i = 0; i < 2; i++) begin
      wbuf[i] = exp[i];
      mbuf[i] = 2'b00;
    end
    xfer(1'b0, 1'b0, 1'b1, 32'h010, 2, 6, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'h010, 2, 0, 1'b0);
    n_tests++;
    if (got !== 2 || ca_rw !== 1'b0 || lat_meas !== 6) begin
      n_fail++;
      $display("FAIL wr_rd_frame: words=%0d ca_rwds=%b lat=%0d, expected 2 0 6",
               got, ca_rw, lat_meas);
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (rbuf[i] !== exp[i] || rwbuf[i] !== 2'b10) begin
        n_fail++;
        $display("FAIL wr_rd_word%0d: data=%h rwds=%b, expected %h 10", i, rbuf[i], rwbuf[i], exp[i]);
      end
    end
  endtask

  task automatic test_mask();
    wbuf[0] = 16'h1234;
    mbuf[0] = 2'b00;
    xfer(1'b0, 1'b0, 1'b1, 32'h005, 1, 6, 1'b0);
    wbuf[0] = 16'hABCD;
    mbuf[0] = 2'b10;
    xfer(1'b0, 1'b0, 1'b1, 32'h005, 1, 6, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'h005, 1, 0, 1'b0);
    n_tests++;
    if (got !== 1 || rbuf[0] !== 16'h12CD) begin
      n_fail++;
      $display("FAIL masked_write: words=%0d data=%h, expected 1 12cd", got, rbuf[0]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp [4];
    wbuf[0] = 16'h1E1E; wbuf[1] = 16'h1F1F;
    mbuf[0] = 2'b00;    mbuf[1] = 2'b00;
    xfer(1'b0, 1'b0, 1'b1, 32'h01E, 2, 6, 1'b0);
    exp[0] = 16'h1E1E; exp[1] = 16'h1F1F; exp[2] = 16'hA1B2; exp[3] = 16'hC3D4;
    xfer(1'b1, 1'b0, 1'b0, 32'h01E, 4, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (i >= got || rbuf[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL wrap_word%0d: words=%0d data=%h, expected %h", i, got, rbuf[i], exp[i]);
      end
    end
    wbuf[0] = 16'h5A5A; wbuf[1] = 16'h6B6B;
    xfer(1'b0, 1'b0, 1'b1, 32'h3FF, 2, 6, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'h3FF, 2, 0, 1'b0);
    n_tests++;
    if (got !== 2 || rbuf[0] !== 16'h5A5A || rbuf[1] !== 16'h6B6B) begin
      n_fail++;
      $display("FAIL linear_top: words=%0d data=%h %h, expected 2 5a5a 6b6b", got, rbuf[0], rbuf[1]);
    end
  endtask

  task automatic test_cs_abort();
    hb_ck = 1'b0;
    wait_clk(4);
    cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 3; i++) begin
      dq_i = 8'hA0;
      hb_ck = ~hb_ck;
      wait_clk(4);
    end
    n_tests++;
    if (rwds_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_ca_active: rwds_oe=%b, expected 1", rwds_oe);
    end
    cs_n = 1'b1;
    wait_clk(2);
    n_tests++;
    if (rwds_oe !== 1'b0 || dq_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_ca_abort: dq_oe=%b rwds_oe=%b, expected 0 0", dq_oe, rwds_oe);
    end
    xfer(1'b1, 1'b0, 1'b1, 32'h010, 1, 0, 1'b1);
    n_tests++;
    if (dq_oe !== 1'b1 || rwds_oe !== 1'b1 || rbuf[0] !== 16'hA1B2) begin
      n_fail++;
      $display("FAIL mid_rd_active: dq_oe=%b rwds_oe=%b data=%h, expected 1 1 a1b2",
               dq_oe, rwds_oe, rbuf[0]);
    end
    cs_n = 1'b1;
    wait_clk(2);
    n_tests++;
    if (rwds_oe !== 1'b0 || dq_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rd_abort: dq_oe=%b rwds_oe=%b, expected 0 0", dq_oe, rwds_oe);
    end
    wait_clk(2);
    xfer(1'b1, 1'b0, 1'b1, 32'h011, 1, 0, 1'b0);
    n_tests++;
    if (got !== 1 || rbuf[0] !== 16'hC3D4) begin
      n_fail++;
      $display("FAIL after_abort: words=%0d data=%h, expected 1 c3d4", got, rbuf[0]);
    end
  endtask

  task automatic test_async_reset();
    xfer(1'b1, 1'b0, 1'b1, 32'h010, 1, 0, 1'b1);
    n_tests++;
    if (dq_oe !== 1'b1 || rwds_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre: dq_oe=%b rwds_oe=%b, expected 1 1", dq_oe, rwds_oe);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dq_oe !== 1'b0 || rwds_oe !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_drop: dq_oe=%b rwds_oe=%b, expected 0 0", dq_oe, rwds_oe);
    end
    cs_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    n_tests++;
    if (cr0 !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL arst_cr0: got %h, expected 8f1f", cr0);
    end
    xfer(1'b1, 1'b1, 1'b1, 32'h000, 1, 0, 1'b0);
    n_tests++;
    if (got !== 1 || rbuf[0] !== 16'h0C81) begin
      n_fail++;
      $display("FAIL id0_read: words=%0d data=%h, expected 1 0c81", got, rbuf[0]);
    end
    n_tests++;
    if (ca_rw !== 1'b1 || lat_meas !== 12) begin
      n_fail++;
      $display("FAIL id0_2x: ca_rwds=%b lat=%0d, expected 1 12", ca_rw, lat_meas);
    end
  endtask

  initial begin
    test_reset();
    test_cr0();
    test_write_read();
    test_mask();
    test_wrap();
    test_cs_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hyper_ram_emu.md
Name: hyper_ram_emu

Overview:
- Synthesizable HyperBus responder (HyperRAM device emulator) backed by on-chip block RAM.
- Connects directly to the HyperBus pins of the team's HyperBus controller, for on-FPGA loopback bring-up and simulation without an external HyperRAM.
- Oversamples hb_ck_i in the system clock domain and decodes the command/address (CA) phase.
- Applies latency, then serves DDR read/write bursts and register-space (ID0/CR0) accesses.

Parameters:
ADDR_W, 10, word (16-bit) address width of the backing RAM; CA word address is truncated to ADDR_W bits.
LATENCY, 6, initial latency in hb_ck cycles (1x); 2x doubles it.
ID0_VAL, 16'h0C81, value returned for register reads of word address 0.
CR0_RST, 16'h8F1F, CR0 reset value.

Ports:
wb_clk_i  in  1  system clock; all logic on rising edge; must run ≥4x hb_ck frequency.
wb_rst_ni  in  1  asynchronous active-low reset.
hb_ck_i  in  1  HyperBus clock from the initiator, sampled as data.
hb_cs_ni  in  1  chip select, active low.
hb_rst_ni  in  1  device reset from the initiator, active low, sampled synchronously.
hb_dq_i  in  8  DQ from the initiator.
hb_dq_o  out  8  DQ driven by this block.
hb_dq_oe  out  1  1 = this block drives DQ.
hb_rwds_i  in  1  RWDS from the initiator (write byte mask, 1 = masked).
hb_rwds_o  out  1  RWDS driven by this block.
hb_rwds_oe  out  1  1 = this block drives RWDS.
cr0_o  out  16  current CR0 value, for debug.

Behaviour:
- Reset (wb_rst_ni low, async):
  - hb_dq_o=0, hb_dq_oe=0, hb_rwds_o=0, hb_rwds_oe=0.
  - CR0=CR0_RST; state IDLE.
  - RAM contents undefined.
- hb_rst_ni low (sync): same effect as reset, except RAM is untouched.
- Edge detection:
  - hb_ck_i, hb_dq_i, hb_rwds_i and hb_cs_ni are registered once.
  - An edge is ck_q != ck_qq; data is captured from the same registered stage on the edge cycle.
- CS rules:
  - hb_cs_ni high in any state → IDLE next clk; oe outputs low in that same next clk; pending partial write words are discarded.
  - Falling hb_cs_ni in IDLE → CA state.
- CA state:
  - Captures 6 bytes on 6 consecutive hb_ck edges, MSB byte first, into ca[47:0].
  - ca[47]=read; ca[46]=register space; ca[45]=linear (0 = wrapped).
  - Word address = {ca[44:16], ca[2:0]} truncated to ADDR_W.
  - hb_rwds_oe=1 during CA; hb_rwds_o=two_x, where two_x=CR0[3] (fixed-latency bit).
- After the 6th CA edge:
  - Register write → REGWR with zero latency.
  - Otherwise → LAT with count = LATENCY*(two_x?2:1).
- LAT: decrement on each rising hb_ck edge. At 0 → RD (read) or WR (write). LATENCY=0 goes directly.
- RD:
  - Drives hb_dq_oe=hb_rwds_oe=1.
  - On each rising edge: hb_dq_o=word[15:8], hb_rwds_o=1.
  - On each falling edge: hb_dq_o=word[7:0], hb_rwds_o=0.
  - Output updates one clk after the edge-detect cycle.
  - RAM read is issued one edge ahead (prefetch), so the next word is ready by the next rising edge.
- WR:
  - DQ/RWDS are inputs.
  - Rising-edge byte → upper byte, written unless hb_rwds_i=1.
  - Falling-edge byte → lower byte, same masking rule.
  - Write to RAM after the falling-edge byte, with 2-bit byte enables.
- Address increment, per word:
  - Linear bursts wrap at 2^ADDR_W.
  - Wrapped bursts wrap within the aligned 16-word group (low 4 bits only).
- Register space:
  - Read word addr 0 → ID0_VAL; addr with bit 11 set (0x800) → CR0; any other address → 0. Repeats for longer bursts.
  - Write to 0x800 → CR0 = first data word (both bytes, mask ignored). Other addresses are ignored.
  - After the first word: DONE state, idle until CS high.
- Changes to CR0[3] take effect from the next transaction.
- No refresh collisions are emulated.

Test Plan:
- Write 2 words 0xA1B2, 0xC3D4 to word addr 0x010 (1x, LATENCY=6), then read 2 → read bytes A1,B2,C3,D4 with RWDS toggling 1,0,1,0; RWDS low during CA.
- Write CR0=0x8F17 then read reg 0x800 → 0x8F17; cr0_o=0x8F17; subsequent CA shows RWDS=0 and latency of 6 hb_ck cycles. Reset back to CR0_RST gives RWDS=1 and latency of 12 cycles.
- Masked write: old word 0x1234 at addr 5; write 0xABCD with RWDS=1 on the upper byte → reads 0x12CD.
- Wrapped read starting at word 0x01E, 4 words → words 0x01E, 0x01F, 0x010, 0x011. Linear read starting at 0x3FF → 0x3FF, 0x000.
- CS deasserted mid-CA (after 3 bytes) and mid-read → oe outputs 0 within 2 clk; next full transaction decodes correctly.
- wb_rst_ni asserted during a read burst → oe outputs drop immediately (async); after release, ID0 read returns 0x0C81.
